// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory store checker: FSM states, failure causes
// and a width helper used to size table indices.
package chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} chk_state_t;
  typedef enum logic [1:0] {C_NONE, C_ADDR, C_DATA, C_TIMEOUT} chk_cause_t;

  // A one-entry table still needs a one-bit index port.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Data-memory write bus as seen between a MIPS core (master) and the
// store checker (slave).
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;

  modport master (
    output memwrite,
    output dataadr,
    output writedata
  );

  modport slave (
    input memwrite,
    input dataadr,
    input writedata
  );

endinterface

// File: rtl/mem_write_checker_exp_table.sv
// Expected-store register file: one synchronous write port and an
// asynchronous read port addressed by the running match count.
module chk_exp_table #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (we && (int'(widx) < DEPTH)) begin
      addr_mem[widx] <= waddr;
      data_mem[widx] <= wdata;
    end
  end

  always_comb begin
    raddr = '0;
    rdata = '0;
    if (int'(ridx) < DEPTH) begin
      raddr = addr_mem[ridx];
      rdata = data_mem[ridx];
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Store-stream self-check monitor: compares observed data-memory writes with
// a programmed ordered list, tolerating an address window, with a timeout.
module mem_write_checker
  import chk_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096,
  parameter int IGN_LO  = 80,
  parameter int IGN_HI  = 80,
  localparam int IDX_W  = idx_width(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  mem_write_checker_if.slave  bus,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]   cfg_data,
  input  logic [CNT_W-1:0]    cfg_len,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [1:0]          fail_cause,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_data,
  output logic [CNT_W-1:0]    match_cnt
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] IGN_LO_A = ADDR_W'(IGN_LO);
  localparam logic [ADDR_W-1:0] IGN_HI_A = ADDR_W'(IGN_HI);
  localparam bit                IGN_EN   = (IGN_HI >= IGN_LO);

  chk_state_t        state_q, state_d;
  chk_cause_t        cause_q, cause_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              addr_hit;
  logic              data_hit;
  logic              in_window;
  logic              tab_we;

  // The table is frozen while a check runs so the reference cannot shift.
  assign tab_we = cfg_we && (state_q != RUN);

  chk_exp_table #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (tab_we),
    .widx  (cfg_idx),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .ridx  (match_q[IDX_W-1:0]),
    .raddr (exp_addr),
    .rdata (exp_data)
  );

  assign addr_hit  = bus.memwrite && (bus.dataadr == exp_addr);
  assign data_hit  = (bus.writedata == exp_data);
  assign in_window = IGN_EN && (bus.dataadr >= IGN_LO_A) && (bus.dataadr <= IGN_HI_A);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cause_q <= C_NONE;
      len_q   <= '0;
      match_q <= '0;
      cnt_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      len_q   <= len_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  // A store landing in the expiry cycle is judged before the timeout; the
  // counter saturates so a late partial match only postpones expiry by one.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    len_d   = len_q;
    match_d = match_q;
    cnt_d   = cnt_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    case (state_q)
      RUN: begin
        if (cnt_q != TO_LAST) begin
          cnt_d = cnt_q + TO_W'(1);
        end
        if (len_q == '0) begin
          state_d = PASS;
        end else if (addr_hit && data_hit) begin
          match_d = match_q + CNT_W'(1);
          if (match_d == len_q) begin
            state_d = PASS;
          end
        end else if (addr_hit) begin
          state_d = FAIL;
          cause_d = C_DATA;
          faddr_d = bus.dataadr;
          fdata_d = bus.writedata;
        end else if (bus.memwrite && !in_window) begin
          state_d = FAIL;
          cause_d = C_ADDR;
          faddr_d = bus.dataadr;
          fdata_d = bus.writedata;
        end else if (cnt_q == TO_LAST) begin
          state_d = FAIL;
          cause_d = C_TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          cause_d = C_NONE;
          len_d   = (cfg_len > DEPTH_C) ? DEPTH_C : cfg_len;
          match_d = '0;
          cnt_d   = '0;
          faddr_d = '0;
          fdata_d = '0;
        end
      end
    endcase
  end

  assign busy       = (state_q == RUN);
  assign pass       = (state_q == PASS);
  assign fail       = (state_q == FAIL);
  assign done       = pass || fail;
  assign fail_cause = cause_q;
  assign fail_addr  = faddr_q;
  assign fail_data  = fdata_q;
  assign match_cnt  = match_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus randomized store
// streams, all judged against a behavioural model of the store list.
module tb_mem_write_checker;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int IGN_LO  = 80;
  localparam int IGN_HI  = 80;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_idx = '0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic [CNT_W-1:0]  cfg_len = '0;
  logic              start = 1'b0;
  logic              busy, done, pass, fail;
  logic [1:0]        fail_cause;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic [CNT_W-1:0]  match_cnt;

  int nCompared = 0;
  int nMismatched = 0;

  // Behavioural model: the expected list, how far along it we are, how many
  // RUN cycles have elapsed, and the verdict so far.
  logic [31:0] tabA [DEPTH];
  logic [31:0] tabD [DEPTH];
  bit          mBusy, mPass, mFail;
  int          mCause, mMatch, mLen, mElapsed;
  logic [31:0] mFaddr, mFdata;

  mem_write_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_write_checker #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .IGN_LO  (IGN_LO),
    .IGN_HI  (IGN_HI)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_len    (cfg_len),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .fail_cause (fail_cause),
    .fail_addr  (fail_addr),
    .fail_data  (fail_data),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string ph);
    checkOutput({ph, ".busy"},  32'(busy),       32'(mBusy));
    checkOutput({ph, ".done"},  32'(done),       32'(mPass || mFail));
    checkOutput({ph, ".pass"},  32'(pass),       32'(mPass));
    checkOutput({ph, ".fail"},  32'(fail),       32'(mFail));
    checkOutput({ph, ".cause"}, 32'(fail_cause), 32'(mCause));
    checkOutput({ph, ".faddr"}, fail_addr,       mFaddr);
    checkOutput({ph, ".fdata"}, fail_data,       mFdata);
    checkOutput({ph, ".match"}, 32'(match_cnt),  32'(mMatch));
  endtask

  task automatic modelFail(input int cause, input logic [31:0] a, input logic [31:0] d);
    mBusy  = 0;
    mFail  = 1;
    mCause = cause;
    mFaddr = a;
    mFdata = d;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelEdge();
    bit ignored;
    if (mBusy) begin
      mElapsed++;
      ignored = (bus.dataadr >= IGN_LO) && (bus.dataadr <= IGN_HI);
      if (mLen == 0) begin
        mBusy = 0;
        mPass = 1;
      end else if (bus.memwrite && bus.dataadr == tabA[mMatch]) begin
        if (bus.writedata == tabD[mMatch]) begin
          mMatch++;
          if (mMatch == mLen) begin
            mBusy = 0;
            mPass = 1;
          end
        end else begin
          modelFail(2, bus.dataadr, bus.writedata);
        end
      end else if (bus.memwrite && !ignored) begin
        modelFail(1, bus.dataadr, bus.writedata);
      end else if (mElapsed >= TIMEOUT) begin
        modelFail(3, 0, 0);
      end
    end else begin
      if (cfg_we) begin
        tabA[cfg_idx] = cfg_addr;
        tabD[cfg_idx] = cfg_data;
      end
      if (start) begin
        mBusy    = 1;
        mPass    = 0;
        mFail    = 0;
        mCause   = 0;
        mFaddr   = 0;
        mFdata   = 0;
        mMatch   = 0;
        mElapsed = 0;
        mLen     = (int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
      end
    end
  endtask

  task automatic applyStimulus(input logic mw, input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = mw;
    bus.dataadr   = a;
    bus.writedata = d;
    modelEdge();
    @(posedge clk);
    #1;
    checkAll("cyc");
    cfg_we       = 1'b0;
    start        = 1'b0;
    bus.memwrite = 1'b0;
  endtask

  task automatic writeEntry(input int idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we   = 1'b1;
    cfg_idx  = IDX_W'(idx);
    cfg_addr = a;
    cfg_data = d;
    applyStimulus(1'b0, 32'd0, 32'd0);
  endtask

  task automatic armCheck(input int len);
    cfg_len = CNT_W'(len);
    start   = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    mBusy = 0; mPass = 0; mFail = 0;
    mCause = 0; mMatch = 0; mLen = 0; mElapsed = 0;
    mFaddr = 0; mFdata = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tabA[i] = 0;
      tabD[i] = 0;
    end
    checkAll("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int kind;
    logic [31:0] a, d;
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    doReset();

    // Ignored store then matching store.
    writeEntry(0, 32'd84, 32'd7);
    armCheck(1);
    checkOutput("t1.busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 32'd80, 32'd5);
    applyStimulus(1'b1, 32'd84, 32'd7);
    checkOutput("t1.pass",  32'(pass),       32'd1);
    checkOutput("t1.done",  32'(done),       32'd1);
    checkOutput("t1.match", 32'(match_cnt),  32'd1);
    checkOutput("t1.cause", 32'(fail_cause), 32'd0);

    // Right address, wrong data.
    armCheck(1);
    applyStimulus(1'b1, 32'd84, 32'd9);
    checkOutput("t2.fail",  32'(fail),       32'd1);
    checkOutput("t2.cause", 32'(fail_cause), 32'd2);
    checkOutput("t2.faddr", fail_addr,       32'd84);
    checkOutput("t2.fdata", fail_data,       32'd9);

    // Unexpected address.
    armCheck(1);
    applyStimulus(1'b1, 32'd88, 32'd7);
    checkOutput("t3.fail",  32'(fail),       32'd1);
    checkOutput("t3.cause", 32'(fail_cause), 32'd1);
    checkOutput("t3.faddr", fail_addr,       32'd88);

    // Timeout with no stores.
    armCheck(1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 32'd0, 32'd0);
      n++;
      if (fail) break;
    end
    checkOutput("t4.cycles", 32'(n),          32'd16);
    checkOutput("t4.cause",  32'(fail_cause), 32'd3);
    checkOutput("t4.faddr",  fail_addr,       32'd0);

    // Three-entry list with idle gaps, then reset mid-sequence.
    doReset();
    writeEntry(0, 32'd4,  32'd1);
    writeEntry(1, 32'd8,  32'd2);
    writeEntry(2, 32'd12, 32'd3);
    armCheck(3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 32'd0);
      applyStimulus(1'b0, 32'd0, 32'd0);
      applyStimulus(1'b1, 32'(4 * (i + 1)), 32'(i + 1));
      checkOutput("t5.step", 32'(match_cnt), 32'(i + 1));
    end
    checkOutput("t5.pass", 32'(pass), 32'd1);
    armCheck(3);
    applyStimulus(1'b1, 32'd4, 32'd1);
    doReset();
    checkOutput("t5.rst.busy",  32'(busy),      32'd0);
    checkOutput("t5.rst.match", 32'(match_cnt), 32'd0);

    // Cleared table expects a store of zero to address zero.
    armCheck(1);
    applyStimulus(1'b1, 32'd0, 32'd0);
    checkOutput("tbl0.pass", 32'(pass), 32'd1);

    // Zero-length check and re-arm.
    armCheck(0);
    applyStimulus(1'b0, 32'd0, 32'd0);
    checkOutput("t6.pass", 32'(pass), 32'd1);
    armCheck(0);
    checkOutput("t6.rearm.done", 32'(done), 32'd0);
    checkOutput("t6.rearm.pass", 32'(pass), 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0);
    checkOutput("t6.again.pass", 32'(pass), 32'd1);

    // Randomized lists and store streams.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          writeEntry(i, 32'($urandom_range(0, 31)) << 2, 32'($urandom_range(0, 3)));
        end
      end
      armCheck($urandom_range(0, 10));
      for (int c = 0; c < 24 && mBusy; c++) begin
        if ((t % 7) == 3 && c == 3) begin
          doReset();
          break;
        end
        kind = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 31)) << 2;
        d = 32'($urandom_range(0, 3));
        if (kind <= 4) begin
          applyStimulus(1'b1, tabA[mMatch], tabD[mMatch]);
        end else if (kind == 5) begin
          applyStimulus(1'b0, a, d);
        end else if (kind == 6) begin
          applyStimulus(1'b1, 32'd80, d);
        end else if (kind == 7) begin
          applyStimulus(1'b1, tabA[mMatch], tabD[mMatch] ^ 32'd1);
        end else if (kind == 8) begin
          applyStimulus(1'b1, a, d);
        end else begin
          cfg_we   = 1'b1;
          cfg_idx  = IDX_W'(mMatch);
          cfg_addr = a;
          cfg_data = d;
          cfg_len  = 4'd1;
          start    = 1'b1;
          applyStimulus(1'b0, a, d);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
